// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg
// Shared definitions for the shared-register arbiter slice:
//   - default requester count and data width
//   - FSM state encoding (fixed: IDLE=00, GRANT=01, LOAD=10)
package shared_reg_arbiter_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    LOAD  = 2'b10
  } state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin picker. Scans ptr+1, ptr+2, ... modulo N
// and returns the first requester whose bit is set.
// Ports:
//   req    - request vector, bit i = requester i
//   ptr    - index of the most recent winner (lowest priority)
//   valid  - at least one request is set
//   winner - index of the selected requester (0 when valid is low)
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] winner
);

  localparam int unsigned PW = $clog2(N);

  int unsigned        ptr_u;
  logic [2*N-1:0]     dbl;
  logic [N-1:0]       rotated;

  assign ptr_u = {{(32 - PW){1'b0}}, ptr};

  // Rotate so that bit j of 'rotated' is requester (ptr+1+j) mod N; the
  // first set bit from the bottom is then the round-robin winner.
  always_comb begin
    dbl     = {req, req} >> (ptr_u + 32'd1);
    rotated = dbl[N-1:0];
  end

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid && rotated[j]) begin
        valid  = 1'b1;
        winner = PW'((ptr_u + 32'd1 + j) % N);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin arbiter and write sequencer for one shared W-bit register
// written by N requesters. Every transaction takes three cycles:
// IDLE (arbitrate) -> GRANT (one-hot grant, data captured) -> LOAD (done).
// All state changes on the falling edge of C; RE is a synchronous,
// active-high reset sampled on that same edge.
// Ports:
//   C      - clock (falling-edge active)
//   RE     - synchronous active-high reset
//   req    - request vector, bit i = requester i (sampled only in IDLE)
//   wdata  - packed data, requester i on bits [i*W +: W]
//   grant  - one-hot grant, high only in GRANT
//   done   - one-cycle pulse in LOAD after the write committed
//   owner  - index of the current or most recent winner
//   q      - shared register contents
//   busy   - high in GRANT and LOAD
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                 C,
  input  logic                 RE,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         grant,
  output logic                 done,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         q,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(N);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [W-1:0]    q_q,     q_d;

  logic            pick_valid;
  logic [PW-1:0]   pick_winner;
  logic [W-1:0]    sel_data;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Data word of the registered owner.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) begin
        sel_data = wdata[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(negedge C) begin
    if (RE) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. ptr resets to N-1 so requester 0 wins first.
  always_ff @(negedge C) begin
    if (RE) begin
      ptr_q   <= PW'(N - 1);
      owner_q <= '0;
      q_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      q_q     <= q_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        q_d     = sel_data;
        state_d = LOAD;
      end
      LOAD: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registered owner only.
  always_comb begin
    grant = '0;
    done  = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      GRANT: begin
        grant = N'(1) << owner_q;
        busy  = 1'b1;
      end
      LOAD: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign owner = owner_q;
  assign q     = q_q;

endmodule
